sdio_cmd_seq: RTL and testbench

- Command sequencer directly upstream of the SDIO command TX/RX engine.
- Accepts command requests from the uDMA register/config side over a valid/ready handshake and drives the engine's start/op/arg/rsp_type and clear-status inputs.
- Waits for completion (eot, early error status or watchdog), optionally retries failed commands, then captures response and status for software and pulses done/err events.

---
 rtl/sdio_cmd_seq.sv | 175 +++++++++++++++++
 tb/tb_sdio_cmd_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_seq.sv
// Runs one SDIO command at a time into the engine, with optional retry, and reports the result.
// clr_stat at accept+1, cmd_start at +2, done 2 cycles after exit; req_ready_o low while busy (no queueing).
module sdio_cmd_seq #(
    parameter int MAX_RETRY = 2,
    parameter int WDOG_W    = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [5:0]   req_op_i,
    input  logic [31:0]  req_arg_i,
    input  logic [2:0]   req_rsp_type_i,
    input  logic         req_retry_en_i,
    input  logic         abort_i,
    output logic         cmd_start_o,
    output logic [5:0]   cmd_op_o,
    output logic [31:0]  cmd_arg_o,
    output logic [2:0]   cmd_rsp_type_o,
    output logic         clr_stat_o,
    input  logic         eot_i,
    input  logic [5:0]   status_i,
    input  logic [127:0] rsp_data_i,
    output logic [127:0] rsp_data_o,
    output logic [7:0]   status_o,
    output logic [3:0]   retry_cnt_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_WAIT_EOT, S_EVAL, S_ABORT, S_DONE
    } state_t;

    localparam logic [3:0] MAX_ATT = 4'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [31:0]       arg_q, arg_d;
    logic [2:0]        rsp_type_q, rsp_type_d;
    logic              retry_en_q, retry_en_d;
    logic [3:0]        att_q, att_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_flag_q, wdog_flag_d;
    logic [127:0]      hold_rsp_q, hold_rsp_d;
    logic [5:0]        hold_stat_q, hold_stat_d;
    logic [127:0]      rsp_q, rsp_d;
    logic [7:0]        stat_q, stat_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              wdog_zero, fail, retry;

    assign wdog_zero = (wdog_q == '0);
    assign fail      = (hold_stat_q != 6'd0) | wdog_flag_q;
    assign retry     = fail & retry_en_q & (att_q < MAX_ATT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            arg_q       <= '0;
            rsp_type_q  <= '0;
            retry_en_q  <= 1'b0;
            att_q       <= '0;
            wdog_q      <= '0;
            wdog_flag_q <= 1'b0;
            hold_rsp_q  <= '0;
            hold_stat_q <= '0;
            rsp_q       <= '0;
            stat_q      <= '0;
            rcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            rsp_type_q  <= rsp_type_d;
            retry_en_q  <= retry_en_d;
            att_q       <= att_d;
            wdog_q      <= wdog_d;
            wdog_flag_q <= wdog_flag_d;
            hold_rsp_q  <= hold_rsp_d;
            hold_stat_q <= hold_stat_d;
            rsp_q       <= rsp_d;
            stat_q      <= stat_d;
            rcnt_q      <= rcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        rsp_type_d  = rsp_type_q;
        retry_en_d  = retry_en_q;
        att_d       = att_q;
        wdog_d      = wdog_q;
        wdog_flag_d = wdog_flag_q;
        hold_rsp_d  = hold_rsp_q;
        hold_stat_d = hold_stat_q;
        rsp_d       = rsp_q;
        stat_d      = stat_q;
        rcnt_d      = rcnt_q;
        cmd_start_o = 1'b0;
        clr_stat_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d       = req_op_i;
                    arg_d      = req_arg_i;
                    rsp_type_d = req_rsp_type_i;
                    retry_en_d = req_retry_en_i;
                    att_d      = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_stat_o = 1'b1;
                wdog_d     = '1;
                state_d    = abort_i ? S_ABORT : S_START;
            end
            S_START: begin
                // Counting starts here so WAIT_EOT lasts exactly 2^WDOG_W-1 cycles.
                cmd_start_o = 1'b1;
                wdog_d      = wdog_q - WDOG_W'(1);
                state_d     = abort_i ? S_ABORT : S_WAIT_EOT;
            end
            S_WAIT_EOT: begin
                wdog_d = wdog_q - WDOG_W'(1);
                if (abort_i) begin
                    state_d = S_ABORT;
                end else if (eot_i || (status_i[1:0] != 2'b00) || wdog_zero) begin
                    hold_rsp_d  = rsp_data_i;
                    hold_stat_d = status_i;
                    wdog_flag_d = ~eot_i & (status_i[1:0] == 2'b00);
                    state_d     = S_EVAL;
                end
            end
            S_EVAL: begin
                if (retry) begin
                    att_d   = att_q + 4'd1;
                    state_d = S_CLEAR;
                end else begin
                    // A silent engine may still be mid-command; force it back to idle.
                    clr_stat_o = wdog_flag_q;
                    rsp_d      = hold_rsp_q;
                    stat_d     = {1'b0, wdog_flag_q, hold_stat_q};
                    rcnt_d     = att_q;
                    state_d    = S_DONE;
                end
            end
            S_ABORT: begin
                clr_stat_o = 1'b1;
                stat_d     = {2'b10, status_i};
                rcnt_d     = att_q;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rst_i) begin
            cmd_start_o = 1'b0;
            clr_stat_o  = 1'b0;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE) & ~rst_i;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign err_o          = done_o & (stat_q != 8'h00);
    assign cmd_op_o       = op_q;
    assign cmd_arg_o      = arg_q;
    assign cmd_rsp_type_o = rsp_type_q;
    assign rsp_data_o     = rsp_q;
    assign status_o       = stat_q;
    assign retry_cnt_o    = rcnt_q;
endmodule

// File: tb/tb_sdio_cmd_seq.sv
// Bench for sdio_cmd_seq: scenario table driven through a small engine responder,
// plus directed abort and mid-command reset sequences.
module tb_sdio_cmd_seq;
    localparam logic [1:0] K_EOT = 2'd0, K_ERR = 2'd1, K_SIL = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_i, sel, req_valid_a, req_valid_b, retry_en, abort_i, eot_i;
    logic [5:0]   op, status_i;
    logic [31:0]  arg;
    logic [2:0]   typ;
    logic [127:0] rsp_i;

    logic         rdy_a, start_a, clr_a, busy_a, done_a, err_a;
    logic [5:0]   op_a;
    logic [31:0]  arg_a;
    logic [2:0]   typ_a;
    logic [127:0] rsp_a;
    logic [7:0]   st_a;
    logic [3:0]   rc_a;
    logic         rdy_b, start_b, clr_b, busy_b, done_b, err_b;
    logic [5:0]   op_b;
    logic [31:0]  arg_b;
    logic [2:0]   typ_b;
    logic [127:0] rsp_b;
    logic [7:0]   st_b;
    logic [3:0]   rc_b;

    sdio_cmd_seq u_dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_a), .req_ready_o(rdy_a),
        .req_op_i(op), .req_arg_i(arg), .req_rsp_type_i(typ), .req_retry_en_i(retry_en),
        .abort_i(abort_i), .cmd_start_o(start_a), .cmd_op_o(op_a), .cmd_arg_o(arg_a),
        .cmd_rsp_type_o(typ_a), .clr_stat_o(clr_a), .eot_i(eot_i), .status_i(status_i),
        .rsp_data_i(rsp_i), .rsp_data_o(rsp_a), .status_o(st_a), .retry_cnt_o(rc_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    // Small watchdog (15 cycles) and no retries allowed.
    sdio_cmd_seq #(.MAX_RETRY(0), .WDOG_W(4)) u_dut_w (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_b), .req_ready_o(rdy_b),
        .req_op_i(op), .req_arg_i(arg), .req_rsp_type_i(typ), .req_retry_en_i(retry_en),
        .abort_i(abort_i), .cmd_start_o(start_b), .cmd_op_o(op_b), .cmd_arg_o(arg_b),
        .cmd_rsp_type_o(typ_b), .clr_stat_o(clr_b), .eot_i(eot_i), .status_i(status_i),
        .rsp_data_i(rsp_i), .rsp_data_o(rsp_b), .status_o(st_b), .retry_cnt_o(rc_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    logic         o_rdy, o_start, o_clr, o_busy, o_done, o_err;
    logic [5:0]   o_op;
    logic [31:0]  o_arg;
    logic [2:0]   o_typ;
    logic [127:0] o_rsp;
    logic [7:0]   o_st;
    logic [3:0]   o_rc;
    assign o_rdy   = sel ? rdy_b   : rdy_a;
    assign o_start = sel ? start_b : start_a;
    assign o_clr   = sel ? clr_b   : clr_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_err   = sel ? err_b   : err_a;
    assign o_op    = sel ? op_b    : op_a;
    assign o_arg   = sel ? arg_b   : arg_a;
    assign o_typ   = sel ? typ_b   : typ_a;
    assign o_rsp   = sel ? rsp_b   : rsp_a;
    assign o_st    = sel ? st_b    : st_a;
    assign o_rc    = sel ? rc_b    : rc_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic            sel;
        logic            ren;
        logic [5:0]      op;
        logic [31:0]     arg;
        logic [2:0]      typ;
        logic [31:0]     rsp;
        logic [1:0]      nat;
        logic [2:0][1:0] kind;
        logic [2:0][5:0] st;
        logic [2:0][7:0] dly;
        logic [7:0]      est;
        logic [3:0]      er;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic re, input logic [5:0] o,
            input logic [31:0] a, input logic [2:0] t, input logic [31:0] r, input logic [1:0] n,
            input logic [1:0] k0, input logic [5:0] s0, input logic [7:0] d0,
            input logic [1:0] k1, input logic [5:0] s1, input logic [7:0] d1,
            input logic [1:0] k2, input logic [5:0] s2, input logic [7:0] d2,
            input logic [7:0] est, input logic [3:0] er);
        vec_t v;
        v.sel = s; v.ren = re; v.op = o; v.arg = a; v.typ = t; v.rsp = r; v.nat = n;
        v.kind[0] = k0; v.st[0] = s0; v.dly[0] = d0;
        v.kind[1] = k1; v.st[1] = s1; v.dly[1] = d1;
        v.kind[2] = k2; v.st[2] = s2; v.dly[2] = d2;
        v.est = est; v.er = er;
        return v;
    endfunction

    localparam int NV = 9;
    vec_t vecs [NV];
    logic [127:0] last_rsp_a = '0;

    task automatic run_vec(input int i);
        vec_t v;
        string p;
        int t_acc, first_clr, first_st, e_cyc, done_cyc, clr_n, st_n, done_n, cd, att, last, exp_clr, wd_t;
        logic [1:0] kind;
        logic [5:0] kst, nstat;
        logic neot;
        logic [127:0] exp_rsp;
        v = vecs[i];
        p = $sformatf("v%0d", i);
        t_acc = -1; first_clr = -1; first_st = -1; e_cyc = -1; done_cyc = -1;
        clr_n = 0; st_n = 0; done_n = 0; cd = 0; att = 0; kind = K_SIL; kst = 6'd0;
        wd_t = v.sel ? 15 : 65535;
        exp_rsp = {v.rsp, 64'h0123_4567_89AB_CDEF, v.rsp};
        @(posedge clk); #1;
        sel = v.sel; rsp_i = exp_rsp; op = v.op; arg = v.arg; typ = v.typ; retry_en = v.ren;
        if (v.sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (t_acc < 0 && o_rdy) t_acc = cyc;
            neot  = 1'b0;
            nstat = status_i;
            if (o_clr) begin
                clr_n++;
                if (first_clr < 0) first_clr = cyc;
                nstat = 6'd0;
            end
            if (o_start) begin
                if (st_n == 0) first_st = cyc;
                else chk_i({p, " restart spacing"}, cyc, e_cyc + 3);
                st_n++;
                if (att < 3) begin
                    kind = v.kind[att[1:0]]; kst = v.st[att[1:0]]; cd = int'(v.dly[att[1:0]]);
                end else begin
                    kind = K_SIL; cd = 0;
                end
                att++;
                if (kind == K_SIL) begin
                    cd = 0;
                    e_cyc = cyc + wd_t;
                end
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    e_cyc = cyc + 1;
                    nstat = kst;
                    neot  = (kind == K_EOT);
                end
            end
            if (o_done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk_i({p, " done latency"}, cyc, e_cyc + 2);
                    chk({p, " status"}, 128'(o_st), 128'(v.est));
                    chk({p, " err"}, 128'(o_err), 128'(v.est != 8'h00));
                    chk({p, " retry_cnt"}, 128'(o_rc), 128'(v.er));
                    chk({p, " rsp_data"}, o_rsp, exp_rsp);
                    chk({p, " cmd op/arg/type"}, 128'({o_op, o_arg, o_typ}), 128'({v.op, v.arg, v.typ}));
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                chk({p, " idle after done"}, 128'({o_busy, o_rdy}), 128'(2'b01));
                break;
            end
            @(posedge clk); #1;
            if (t_acc >= 0) begin
                req_valid_a = 1'b0;
                req_valid_b = 1'b0;
            end
            eot_i    = neot;
            status_i = nstat;
        end
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        eot_i = 1'b0;
        last = int'(v.nat) - 1;
        exp_clr = int'(v.nat) + ((v.kind[last[1:0]] == K_SIL) ? 1 : 0);
        chk_i({p, " done pulses"}, done_n, 1);
        chk_i({p, " start pulses"}, st_n, int'(v.nat));
        chk_i({p, " clr pulses"}, clr_n, exp_clr);
        chk_i({p, " first clr"}, first_clr, t_acc + 1);
        chk_i({p, " first start"}, first_st, t_acc + 2);
        if (!v.sel) last_rsp_a = exp_rsp;
    endtask

    initial begin
        int s_cyc, acc_n, st_n;
        rst_i = 1'b1; sel = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; retry_en = 1'b0;
        abort_i = 1'b0; eot_i = 1'b0; op = '0; arg = '0; typ = '0; status_i = '0; rsp_i = '0;

        //          sel   ren   op      arg            typ   rsp             n     attempt0               attempt1               attempt2               est    er
        vecs[0] = mk(1'b0, 1'b0, 6'd8,  32'h0000_01AA, 3'd1, 32'h0000_01AA, 2'd1, K_EOT, 6'h00, 8'd60, K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h00, 4'd0);
        vecs[1] = mk(1'b0, 1'b1, 6'd5,  32'h0000_0000, 3'd2, 32'hDEAD_0001, 2'd3, K_ERR, 6'h01, 8'd10, K_ERR, 6'h01, 8'd12, K_ERR, 6'h01, 8'd9, 8'h01, 4'd2);
        vecs[2] = mk(1'b0, 1'b1, 6'd52, 32'h1234_5678, 3'd4, 32'hBEEF_0002, 2'd2, K_ERR, 6'h02, 8'd7,  K_EOT, 6'h00, 8'd20, K_SIL, 6'h00, 8'd0, 8'h00, 4'd1);
        vecs[3] = mk(1'b0, 1'b0, 6'd17, 32'hFFFF_FFFF, 3'd1, 32'h0000_0003, 2'd1, K_ERR, 6'h02, 8'd5,  K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h02, 4'd0);
        vecs[4] = mk(1'b0, 1'b1, 6'd7,  32'h0000_A5A5, 3'd5, 32'h0000_0004, 2'd2, K_EOT, 6'h04, 8'd8,  K_EOT, 6'h00, 8'd8,  K_SIL, 6'h00, 8'd0, 8'h00, 4'd1);
        vecs[5] = mk(1'b1, 1'b0, 6'd2,  32'h0000_0000, 3'd3, 32'h0000_0005, 2'd1, K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h40, 4'd0);
        vecs[6] = mk(1'b1, 1'b0, 6'd9,  32'h0000_0009, 3'd1, 32'h0000_0006, 2'd1, K_EOT, 6'h00, 8'd15, K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h00, 4'd0);
        vecs[7] = mk(1'b1, 1'b1, 6'd12, 32'h0000_000C, 3'd1, 32'h0000_0007, 2'd1, K_ERR, 6'h02, 8'd4,  K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h02, 4'd0);
        vecs[8] = mk(1'b1, 1'b1, 6'd13, 32'h0000_000D, 3'd1, 32'h0000_0008, 2'd1, K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0,  K_SIL, 6'h00, 8'd0, 8'h40, 4'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready low in reset", 128'({rdy_a, rdy_b}), 128'(2'b00));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset ready", 128'({rdy_a, rdy_b}), 128'(2'b11));
        chk("reset pulses/busy", 128'({busy_a, done_a, err_a, start_a, clr_a, busy_b, done_b}), 128'(0));
        chk("reset results", {rsp_a[119:0], st_a}, 128'(0));
        chk("reset cmd regs", 128'({op_a, arg_a, typ_a, rc_a}), 128'(0));

        for (int i = 0; i < NV; i++) run_vec(i);

        // Abort five cycles into WAIT_EOT, colliding with eot.
        @(posedge clk); #1;
        sel = 1'b0; op = 6'd3; arg = 32'h0000_0777; typ = 3'd1; retry_en = 1'b1;
        rsp_i = {4{32'hFEED_FACE}}; status_i = 6'h00; eot_i = 1'b0;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        s_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_start) begin
                s_cyc = cyc;
                break;
            end
        end
        chk("abort start seen", 128'(s_cyc >= 0), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        abort_i = 1'b1; eot_i = 1'b1; status_i = 6'h04;
        @(negedge clk);
        chk("abort cycle clr/done", 128'({o_clr, o_done}), 128'(2'b00));
        @(posedge clk); #1;
        abort_i = 1'b0; eot_i = 1'b0;
        @(negedge clk);
        chk("abort clr pulse", 128'({o_clr, o_start, o_done}), 128'(3'b100));
        @(posedge clk); #1;
        status_i = 6'h00;
        @(negedge clk);
        chk("abort done/err", 128'({o_done, o_err}), 128'(2'b11));
        chk("abort status", 128'(o_st), 128'(8'h84));
        chk("abort rsp unchanged", o_rsp, last_rsp_a);
        chk("abort retry_cnt", 128'(o_rc), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort back to idle", 128'({o_done, o_busy}), 128'(2'b00));

        // Valid held through a busy command, then reset in WAIT_EOT.
        @(posedge clk); #1;
        op = 6'd33; arg = 32'h5555_AAAA; typ = 3'd1; retry_en = 1'b0; req_valid_a = 1'b1;
        acc_n = 0; st_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_rdy) acc_n++;
            if (o_start) st_n++;
            @(posedge clk); #1;
        end
        chk_i("held valid acceptances", acc_n, 1);
        chk_i("held valid starts", st_n, 1);
        chk("busy in WAIT_EOT", 128'(o_busy), 128'(1));
        rst_i = 1'b1;
        @(negedge clk);
        chk("reset cycle engine pulses", 128'({o_clr, o_start, o_rdy}), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("in reset idle not ready", 128'({o_busy, o_rdy, o_clr, o_start}), 128'(0));
        @(posedge clk); #1;
        rst_i = 1'b0; req_valid_a = 1'b0;
        @(negedge clk);
        chk("post reset ready/busy", 128'({o_rdy, o_busy, o_done}), 128'(3'b100));
        chk("post reset results", {o_rsp[119:0], o_st}, 128'(0));
        chk("post reset regs", 128'({o_op, o_arg, o_typ, o_rc}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
